// File: rtl/pipelined_controller.sv
// Hazard and halt controller for an in-order pipeline: scoreboard of in-flight
// writers after ID, load-use stall, one-hot forwarding select, ecall drain/halt.
module pipelined_controller #(
    parameter int STAGES = 3,
    parameter int REG_W  = 5
) (
    input  logic [4:0]        LOGISIM_CLOCK_TREE_0,
    input  logic              nRESET,
    input  logic              id_valid,
    input  logic [4:0]        OP,
    input  logic [4:0]        Funct,
    input  logic              IR21,
    input  logic [REG_W-1:0]  rs1,
    input  logic [REG_W-1:0]  rs2,
    input  logic [REG_W-1:0]  rd,
    input  logic              branch_taken,
    input  logic              resume,
    output logic              stall,
    output logic              flush,
    output logic [STAGES-2:0] fwd_a,
    output logic [STAGES-2:0] fwd_b,
    output logic              halt,
    output logic              uret
);

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALT} state_t;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             is_load;
    } sb_entry_t;

    logic       w_clk;
    logic       w_unused_bits;
    state_t     r_state;
    state_t     w_state_next;
    sb_entry_t  r_sb [1:STAGES];

    logic w_rs1_used, w_rs2_used, w_wr, w_is_load, w_is_sys;
    logic w_writes_rd, w_load_use, w_issue, w_sb_any;

    assign w_clk         = LOGISIM_CLOCK_TREE_0[4];
    // Only bit 4 of the clock tree is a real clock; Funct carries no decode-relevant info here.
    assign w_unused_bits = ^{LOGISIM_CLOCK_TREE_0[3:0], Funct};

    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    always_comb begin
        w_rs1_used = 1'b0;
        w_rs2_used = 1'b0;
        w_wr       = 1'b0;
        w_is_load  = 1'b0;
        w_is_sys   = 1'b0;
        case (OP)
            OPC_LOAD:   begin w_rs1_used = 1'b1; w_wr = 1'b1; w_is_load = 1'b1; end
            OPC_STORE:  begin w_rs1_used = 1'b1; w_rs2_used = 1'b1; end
            OPC_BRANCH: begin w_rs1_used = 1'b1; w_rs2_used = 1'b1; end
            OPC_JAL:    w_wr = 1'b1;
            OPC_JALR:   begin w_rs1_used = 1'b1; w_wr = 1'b1; end
            OPC_OP:     begin w_rs1_used = 1'b1; w_rs2_used = 1'b1; w_wr = 1'b1; end
            OPC_OPIMM:  begin w_rs1_used = 1'b1; w_wr = 1'b1; end
            OPC_LUI:    w_wr = 1'b1;
            OPC_AUIPC:  w_wr = 1'b1;
            OPC_SYSTEM: w_is_sys = 1'b1;
            default:    ;
        endcase
    end

    assign w_writes_rd = w_wr && (rd != '0);

    assign w_load_use = id_valid && r_sb[1].valid && r_sb[1].is_load &&
                        ((w_rs1_used && (rs1 == r_sb[1].rd)) ||
                         (w_rs2_used && (rs2 == r_sb[1].rd)));

    // Written without referring to stall so the FSM block below stays loop-free.
    assign w_issue = nRESET && id_valid && (r_state == S_RUN) && !branch_taken && !w_load_use;

    always_comb begin
        w_sb_any = 1'b0;
        for (int k = 1; k <= STAGES; k++) w_sb_any = w_sb_any | r_sb[k].valid;
    end

    always_comb begin
        w_state_next = r_state;
        stall        = 1'b0;
        halt         = 1'b0;
        case (r_state)
            S_RUN: begin
                stall = w_load_use && !branch_taken;
                if (w_issue && w_is_sys && !IR21) w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                stall = 1'b1;
                if (!w_sb_any) w_state_next = S_HALT;
            end
            S_HALT: begin
                stall = 1'b1;
                halt  = 1'b1;
                if (resume) w_state_next = S_RUN;
            end
            default: w_state_next = S_RUN;
        endcase
    end

    assign flush = nRESET && branch_taken;
    assign uret  = w_issue && w_is_sys && IR21;

    // Scan oldest-to-youngest so the youngest matching producer wins; entry STAGES is excluded.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        if (id_valid && !stall) begin
            for (int k = STAGES - 1; k >= 1; k--) begin
                if (r_sb[k].valid && w_rs1_used && (rs1 == r_sb[k].rd)) begin
                    fwd_a        = '0;
                    fwd_a[k-1]   = 1'b1;
                end
                if (r_sb[k].valid && w_rs2_used && (rs2 == r_sb[k].rd)) begin
                    fwd_b        = '0;
                    fwd_b[k-1]   = 1'b1;
                end
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every entry shifts from its pre-edge value.
    always_ff @(posedge w_clk or negedge nRESET) begin
        if (!nRESET) begin
            r_state <= S_RUN;
            // NOTE: the scoreboard is a handful of flops, not a RAM, so it is cleared on reset.
            for (int k = 1; k <= STAGES; k++) r_sb[k] <= '0;
        end else begin
            r_state <= w_state_next;
            r_sb[1] <= w_issue ? sb_entry_t'{w_writes_rd, rd, w_is_load} : '0;
            for (int k = 2; k <= STAGES; k++) r_sb[k] <= r_sb[k-1];
        end
    end

endmodule
